// File: rtl/rf_sb.sv
// rf_sb: parametrised register file with a per-register busy scoreboard.
// Index 0 is hardwired zero. Read ports are combinational. The issue
// handshake sets busy bits and writeback clears them. busy_cnt is a
// registered population count of the busy bits.
// Optional feature macro: RF_SB_BYPASS_EN. When defined, a read of the
// register being written back this cycle returns the write data directly.
module rf_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int NRP   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRP*AW-1:0]   ra,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic                iss_ready,
    output logic [AW:0]         busy_cnt
);

    // Handshake: an issue is accepted on a rising edge where iss_valid and
    // iss_ready are both high; iss_ready never depends on iss_valid.

    // True for an index that names a real, writable register (not x0).
    function automatic logic legal_idx(input logic [AW-1:0] a);
        return (a != '0) && (int'(a) < NREGS);
    endfunction

    logic [XLEN-1:0] r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic [AW:0]      r_busy_cnt;

    logic w_wr_ok;
    logic w_iss_busy;
    logic w_set;
    logic w_inc;
    logic w_dec;

    assign w_wr_ok    = we && legal_idx(wa);
    assign w_iss_busy = legal_idx(iss_rd) && r_busy[iss_rd];
    // A busy destination may still issue if its producer retires this cycle.
    assign iss_ready  = !w_iss_busy || (we && (wa == iss_rd));
    assign w_set      = iss_valid && iss_ready && legal_idx(iss_rd);
    // Track the exact popcount: count only bits that actually flip.
    assign w_inc      = w_set && !r_busy[iss_rd];
    assign w_dec      = w_wr_ok && r_busy[wa] && !(w_set && (iss_rd == wa));
    assign busy_cnt   = r_busy_cnt;

    // Register storage: writeback writes legal nonzero indices only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wa] <= wd;
        end
    end

    // Busy bits: writeback clears, issue sets; set is applied last so it wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            if (w_wr_ok) begin
                r_busy[wa] <= 1'b0;
            end
            if (w_set) begin
                r_busy[iss_rd] <= 1'b1;
            end
        end
    end

    // Busy counter follows the net number of busy bits that change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_busy_cnt <= r_busy_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
        end
    end

    // Combinational read ports; x0 and out-of-range indices read as zero.
    always_comb begin
        logic [AW-1:0] w_a;
        w_a   = '0;
        rdata = '0;
        rbusy = '0;
        for (int p = 0; p < NRP; p++) begin
            w_a = ra[p*AW +: AW];
            if (legal_idx(w_a)) begin
                rdata[p*XLEN +: XLEN] = r_regs[w_a];
                rbusy[p]              = r_busy[w_a];
`ifdef RF_SB_BYPASS_EN
                if (w_wr_ok && (wa == w_a)) begin
                    rdata[p*XLEN +: XLEN] = wd;
                    rbusy[p]              = w_set && (iss_rd == w_a);
                end
`endif
            end
        end
    end

endmodule
